// File: rtl/sample_packer.sv
// Packs DSR consecutive M-bit samples into one DSR*M-bit frame (first sample at the LSBs)
// and queues completed frames in a small output FIFO with a sticky drop flag.
module sample_packer #(
  parameter int M     = 4,
  parameter int DSR   = 4,
  parameter int DEPTH = 2
) (
  input  logic                                        clkIn,
  input  logic                                        rst,
  input  logic [M-1:0]                                inSample,
  input  logic                                        inValid,
  input  logic                                        sync,
  input  logic                                        clear,
  output logic [DSR*M-1:0]                            outData,
  output logic                                        outValid,
  input  logic                                        outReady,
  output logic [((DSR > 1) ? $clog2(DSR) : 1)-1:0]    cntOut,
  output logic                                        overflow
);

  // Output handshake: a frame transfers on a rising edge where outValid and outReady
  // are both 1. While outValid=1 and outReady=0, outData and outValid do not change.
  // outValid never depends on outReady, and a pushed frame is visible only next cycle.

  localparam int W  = DSR * M;
  localparam int CW = (DSR > 1) ? $clog2(DSR) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(DSR - 1);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [OW-1:0] FULL_OCC  = OW'(DEPTH);

  logic [CW-1:0] cnt;
  logic [CW-1:0] slot;
  logic [W-1:0]  partial;
  logic [W-1:0]  frame;
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [OW-1:0] occ;
  logic          complete;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  // sync restarts the frame: the current sample (if any) lands in slot 0 of an empty frame.
  always_comb begin
    slot                = sync ? '0 : cnt;
    frame               = sync ? '0 : partial;
    frame[slot*M +: M]  = inSample;
    complete            = inValid && (slot == LAST_SLOT);
    full                = (occ == FULL_OCC);
    pop                 = outValid && outReady;
    push                = complete && (!full || pop);
    drop                = complete && full && !pop;
  end

  always_ff @(posedge clkIn or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      partial  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      overflow <= 1'b0;
    end else begin
      if (inValid) begin
        partial <= frame;
        cnt     <= (slot == LAST_SLOT) ? '0 : slot + CW'(1);
      end else if (sync) begin
        partial <= '0;
        cnt     <= '0;
      end

      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      end

      case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase

      // A drop on the same edge as clear keeps the flag set.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear) begin
        overflow <= 1'b0;
      end
    end
  end

  // Frame storage carries no reset; outData is masked to zero while the FIFO is empty.
  always_ff @(posedge clkIn) begin
    if (push) begin
      mem[wr_ptr] <= frame;
    end
  end

  assign outValid = (occ != '0);
  assign outData  = outValid ? mem[rd_ptr] : '0;
  assign cntOut   = cnt;

endmodule
